// File: rtl/instruction_memory_responder.sv
// Instruction memory for the single-cycle MIPS datapath.
// It answers the PC fetch address with the addressed 32-bit instruction one cycle later.
// A byte-serial loader fills the memory while the FSM is out of FETCH.
module instruction_memory_responder #(
  parameter int unsigned NUM_BITS_ADDR_BARRAMENTO = 32,
  parameter int unsigned NUM_BITS_ADDR_PROG       = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_BITS_ADDR_BARRAMENTO-1:0] pc,
  output logic [31:0]                         instr,
  output logic                                instr_valid,
  output logic                                fetch_fault,
  input  logic                                load_en,
  input  logic                                load_valid,
  input  logic [7:0]                          load_byte,
  output logic                                load_ready,
  output logic                                load_done,
  output logic [NUM_BITS_ADDR_PROG-2:0]       load_count,
  output logic                                load_wrap
);

  localparam int unsigned P     = NUM_BITS_ADDR_PROG;
  localparam int unsigned WA    = P - 2;
  localparam int unsigned WORDS = 1 << WA;
  localparam logic [P-2:0] COUNT_MAX = {1'b1, {(P-2){1'b0}}};

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_LOAD,
    ST_FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [WA-1:0] word_addr_q, word_addr_d;
  logic [P-2:0]  load_count_q, load_count_d;
  logic          load_wrap_q, load_wrap_d;
  logic          load_done_q, load_done_d;
  logic [31:0]   instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          fetch_fault_q, fetch_fault_d;

  logic [31:0]   mem_q [WORDS];
  logic          mem_we;
  logic [31:0]   mem_wdata;

  logic          pc_ok;
  logic [WA-1:0] addr_adv;
  logic [P-2:0]  count_adv;
  logic          wrap_adv;
  logic [31:0]   pad_word;

  assign pc_ok = (pc[1:0] == 2'b00) &&
                 (pc[NUM_BITS_ADDR_BARRAMENTO-1:P] == '0);

  // Word-advance values shared by a full-word write and a flush.
  assign addr_adv  = word_addr_q + 1'b1;
  assign wrap_adv  = load_wrap_q | (&word_addr_q);
  assign count_adv = (load_count_q == COUNT_MAX) ? load_count_q : load_count_q + 1'b1;

  // Partial word: the bytes collected so far move to the top, and zeros fill the low bytes.
  always_comb begin
    pad_word = '0;
    case (byte_cnt_q)
      2'd1:    pad_word = {shift_q[7:0], 24'h0};
      2'd2:    pad_word = {shift_q[15:0], 16'h0};
      2'd3:    pad_word = {shift_q, 8'h0};
      default: pad_word = '0;
    endcase
  end

  // Next-state logic, the loader datapath, and the fetch response.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    word_addr_d   = word_addr_q;
    load_count_d  = load_count_q;
    load_wrap_d   = load_wrap_q;
    load_done_d   = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    instr_d       = '0;
    instr_valid_d = 1'b0;
    fetch_fault_d = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        instr_valid_d = 1'b1;
        if (pc_ok) instr_d = mem_q[pc[P-1:2]];
        else       fetch_fault_d = 1'b1;
        if (load_en) begin
          state_d      = ST_LOAD;
          byte_cnt_d   = '0;
          shift_d      = '0;
          word_addr_d  = '0;
          load_count_d = '0;
          load_wrap_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          if (byte_cnt_q == 2'd3) begin
            mem_we       = 1'b1;
            mem_wdata    = {shift_q, load_byte};
            byte_cnt_d   = '0;
            word_addr_d  = addr_adv;
            load_count_d = count_adv;
            load_wrap_d  = wrap_adv;
          end else begin
            shift_d    = {shift_q[15:0], load_byte};
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
        // The exit decision uses the post-accept byte count.
        // A byte that arrives on the falling load_en edge can therefore complete a word and skip FLUSH.
        if (!load_en) begin
          if (byte_cnt_d == 2'd0) begin
            state_d     = ST_FETCH;
            load_done_d = 1'b1;
          end else begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        mem_we       = 1'b1;
        mem_wdata    = pad_word;
        byte_cnt_d   = '0;
        word_addr_d  = addr_adv;
        load_count_d = count_adv;
        load_wrap_d  = wrap_adv;
        state_d      = ST_FETCH;
        load_done_d  = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State register, loader registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      byte_cnt_q    <= '0;
      shift_q       <= '0;
      word_addr_q   <= '0;
      load_count_q  <= '0;
      load_wrap_q   <= 1'b0;
      load_done_q   <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      word_addr_q   <= word_addr_d;
      load_count_q  <= load_count_d;
      load_wrap_q   <= load_wrap_d;
      load_done_q   <= load_done_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  // Program memory: reset clears every word; a single write port serves the loader.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[word_addr_q] <= mem_wdata;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign load_ready  = (state_q == ST_LOAD);
  assign load_done   = load_done_q;
  assign load_count  = load_count_q;
  assign load_wrap   = load_wrap_q;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Scoreboard bench for instruction_memory_responder.
// A word-array model of the program memory predicts each fetch.
// A negedge monitor compares every valid fetch response against the queued prediction.
module tb_instruction_memory_responder;

  localparam int P     = 8;
  localparam int WORDS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        instr_valid, fetch_fault;
  logic        load_en = 1'b0, load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_ready, load_done, load_wrap;
  logic [6:0]  load_count;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [WORDS];
  logic [7:0]  load_bytes[$];
  int          errors = 0;
  int          checks = 0;

  instruction_memory_responder #(
    .NUM_BITS_ADDR_BARRAMENTO(32),
    .NUM_BITS_ADDR_PROG(P)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte),
    .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count), .load_wrap(load_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t expect_for(input logic [31:0] a);
    exp_t e;
    if (a[1:0] != 2'b00 || a >= 32'd256) begin
      e.instr = 32'h0;
      e.fault = 1'b1;
    end else begin
      e.instr = ref_mem[a / 4];
      e.fault = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0:       a = {24'h0, $urandom_range(0, 255)} | 32'h1;
      1:       a = 32'h100 + ($urandom_range(0, 63) * 4);
      2:       a = $urandom;
      default: a = $urandom_range(0, 63) * 4;
    endcase
    return a;
  endfunction

  // Monitor: every valid response from the DUT consumes one prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got instr %h with no prediction queued", instr);
      end else begin
        e = exp_q.pop_front();
        check("fetch_instr", instr, e.instr);
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
      end
    end
  end

  // Each clock edge spent in FETCH is a fetch, so every such edge goes through this task.
  task automatic fetch(input logic [31:0] a);
    pc = a;
    exp_q.push_back(expect_for(a));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    load_en    = 1'b0;
    load_valid = 1'b0;
    reset      = 1'b1;
    #2;
    check("rst_instr", instr, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_fetch_fault", {31'b0, fetch_fault}, 32'h0);
    check("rst_load_done", {31'b0, load_done}, 32'h0);
    check("rst_load_count", {25'b0, load_count}, 32'h0);
    check("rst_load_wrap", {31'b0, load_wrap}, 32'h0);
    check("rst_load_ready", {31'b0, load_ready}, 32'h0);
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Streams load_bytes into the loader, with random gaps between bytes.
  // It then checks the done latency, the word count and the wrap flag against the byte-stream model.
  task automatic do_load(input bit drop_same, input logic [31:0] fpc);
    int n, waited, exp_wait, groups, exp_count;
    logic [31:0] w;
    n = load_bytes.size();
    pc = fpc;
    load_en = 1'b1;
    load_valid = 1'b0;
    exp_q.push_back(expect_for(fpc));
    @(posedge clk); #1;
    check("load_ready_rise", {31'b0, load_ready}, 32'h1);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        load_byte  = 8'($urandom);
        @(posedge clk); #1;
      end
      load_valid = 1'b1;
      load_byte  = load_bytes[i];
      if (i == n - 1 && drop_same) load_en = 1'b0;
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_byte  = 8'($urandom);
    load_en    = 1'b0;
    waited = 0;
    while (load_done !== 1'b1 && waited < 6) begin
      @(posedge clk); #1;
      waited++;
    end
    exp_wait = (drop_same ? 0 : 1) + ((n % 4) != 0 ? 1 : 0);
    check("load_done_latency", waited, exp_wait);
    groups = (n + 3) / 4;
    for (int g = 0; g < groups; g++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++)
        if (4 * g + j < n) w = w | ({24'h0, load_bytes[4 * g + j]} << (24 - 8 * j));
      ref_mem[g % WORDS] = w;
    end
    exp_count = (groups > WORDS) ? WORDS : groups;
    check("load_count", {25'b0, load_count}, exp_count);
    check("load_wrap", {31'b0, load_wrap}, (groups >= WORDS) ? 32'h1 : 32'h0);
    fetch(fpc);
    check("load_done_single_pulse", {31'b0, load_done}, 32'h0);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    fetch(32'h0); fetch(32'h4); fetch(32'h8);

    load_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    do_load(1'b0, 32'h0);
    fetch(32'h0); fetch(32'h4); fetch(32'h8);

    load_bytes = '{8'hAA, 8'hBB, 8'hCC};
    do_load(1'b0, 32'h0);
    fetch(32'h0); fetch(32'h4);

    fetch(32'h2); fetch(32'h100); fetch(32'hFC); fetch(32'hFFFF_FFFC);

    load_bytes.delete();
    for (int i = 0; i < 65 * 4; i++) load_bytes.push_back(8'($urandom));
    do_load(1'b1, 32'h0);
    for (int i = 0; i < WORDS; i++) fetch(32'(i * 4));

    load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_load(1'b1, 32'h4);
    fetch(32'h0); fetch(32'h4); fetch(32'h8);

    for (int t = 0; t < 12; t++) begin
      load_bytes.delete();
      for (int i = 0, n = $urandom_range(1, 40); i < n; i++) load_bytes.push_back(8'($urandom));
      do_load(1'($urandom_range(0, 1)), rand_pc());
      for (int k = 0; k < 6; k++) fetch(rand_pc());
    end

    pc = 32'h0;
    load_en = 1'b1;
    exp_q.push_back(expect_for(32'h0));
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_byte  = 8'hA0 + 8'(i);
      @(posedge clk); #1;
    end
    do_reset();
    fetch(32'h0); fetch(32'h4); fetch(32'h100);
    for (int k = 0; k < 8; k++) fetch(rand_pc());

    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
